nibble_serial_adder: RTL and testbench

//   Multi-cycle wide adder that drives one internal instance of the 4-bit
//   `addition` stage. It slices WIDTH-bit operands into 4-bit nibbles, feeds

---
 rtl/nibble_serial_adder.sv | 149 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: streams WIDTH-bit operands LSB-nibble-first through
// one 4-bit ripple adder, carrying between nibbles in a register.

module addition (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);
  logic [4:0] c;

  assign c[0] = carry_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign carry_out = c[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);
  localparam int NIB   = WIDTH / 4;
  localparam int IDXW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int DEPTH = 1 << IDXW;
  localparam int MSB   = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_lat;
  logic [WIDTH-1:0]  b_lat;
  logic              carry;

  logic [3:0]        a_nib [DEPTH];
  logic [3:0]        b_nib [DEPTH];
  logic [3:0]        add_sum;
  logic              add_cout;
  logic [WIDTH-1:0]  sum_next;
  logic              last;
  logic              ovf_next;

  // Nibble tables are padded to a power of two so idx never selects past the end.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_nib
      if (gi < NIB) begin : g_live
        assign a_nib[gi] = a_lat[gi*4 +: 4];
        assign b_nib[gi] = b_lat[gi*4 +: 4];
      end else begin : g_pad
        assign a_nib[gi] = 4'h0;
        assign b_nib[gi] = 4'h0;
      end
    end
  endgenerate

  addition u_add (
    .a         (a_nib[idx]),
    .b         (b_nib[idx]),
    .carry_in  (carry),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  // Result with the current nibble merged in, so flags see the final word on the last edge.
  generate
    for (gi = 0; gi < NIB; gi++) begin : g_merge
      assign sum_next[gi*4 +: 4] = (idx == IDXW'(gi)) ? add_sum : Sum[gi*4 +: 4];
    end
  endgenerate

  assign last     = (idx == IDXW'(NIB - 1));
  assign ovf_next = (a_lat[MSB] == b_lat[MSB]) && (sum_next[MSB] != a_lat[MSB]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_lat     <= '0;
      b_lat     <= '0;
      carry     <= 1'b0;
      Sum       <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat     <= A;
            b_lat     <= B;
            carry     <= carry_in;
            idx       <= '0;
            Sum       <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          Sum   <= sum_next;
          carry <= add_cout;
          idx   <= idx + IDXW'(1);
          if (last) begin
            carry_out <= add_cout;
            zero      <= ~|sum_next;
            overflow  <= ovf_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder at WIDTH=16 and WIDTH=4, checked
// against a cycle-count/arithmetic model plus literal expectations.

module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s16, c16, busy16, done16, cout16, zero16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        s4, c4, busy4, done4, cout4, zero4, ovf4;
  logic [3:0]  a4, b4, sum4;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(s16), .A(a16), .B(b16), .carry_in(c16),
    .busy(busy16), .done(done16), .Sum(sum16), .carry_out(cout16),
    .zero(zero16), .overflow(ovf16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .carry_in(c4),
    .busy(busy4), .done(done4), .Sum(sum4), .carry_out(cout4),
    .zero(zero4), .overflow(ovf4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted add is busy for one cycle per nibble, then done for one
  // cycle, then idle; results are plain wide arithmetic.
  logic [16:0] r16;
  logic [4:0]  r4;
  assign r16 = 17'(a16) + 17'(b16) + 17'(c16);
  assign r4  = 5'(a4) + 5'(b4) + 5'(c4);

  int          m16_left, m4_left;
  logic        m16_done, m16_valid, m16_cout, m16_zero, m16_ovf;
  logic [15:0] m16_sum;
  logic        m4_done, m4_valid, m4_cout, m4_zero, m4_ovf;
  logic [3:0]  m4_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16_left <= 0; m16_done <= 1'b0; m16_valid <= 1'b1;
      m16_sum <= '0; m16_cout <= 1'b0; m16_zero <= 1'b0; m16_ovf <= 1'b0;
    end else if (m16_left > 0) begin
      m16_left <= m16_left - 1;
      if (m16_left == 1) begin
        m16_done  <= 1'b1;
        m16_valid <= 1'b1;
      end
    end else if (m16_done) begin
      m16_done <= 1'b0;
    end else if (s16) begin
      m16_left  <= 4;
      m16_valid <= 1'b0;
      m16_sum   <= r16[15:0];
      m16_cout  <= r16[16];
      m16_zero  <= (r16[15:0] == 16'h0);
      m16_ovf   <= (a16[15] == b16[15]) && (r16[15] != a16[15]);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4_left <= 0; m4_done <= 1'b0; m4_valid <= 1'b1;
      m4_sum <= '0; m4_cout <= 1'b0; m4_zero <= 1'b0; m4_ovf <= 1'b0;
    end else if (m4_left > 0) begin
      m4_left <= m4_left - 1;
      if (m4_left == 1) begin
        m4_done  <= 1'b1;
        m4_valid <= 1'b1;
      end
    end else if (m4_done) begin
      m4_done <= 1'b0;
    end else if (s4) begin
      m4_left  <= 1;
      m4_valid <= 1'b0;
      m4_sum   <= r4[3:0];
      m4_cout  <= r4[4];
      m4_zero  <= (r4[3:0] == 4'h0);
      m4_ovf   <= (a4[3] == b4[3]) && (r4[3] != a4[3]);
    end
  end

  always @(negedge clk) begin
    chk("busy16", 32'(busy16), 32'(m16_left > 0));
    chk("done16", 32'(done16), 32'(m16_done));
    if (m16_valid) begin
      chk("sum16",  32'(sum16),  32'(m16_sum));
      chk("cout16", 32'(cout16), 32'(m16_cout));
      chk("zero16", 32'(zero16), 32'(m16_zero));
      chk("ovf16",  32'(ovf16),  32'(m16_ovf));
    end
    chk("busy4", 32'(busy4), 32'(m4_left > 0));
    chk("done4", 32'(done4), 32'(m4_done));
    if (m4_valid) begin
      chk("sum4",  32'(sum4),  32'(m4_sum));
      chk("cout4", 32'(cout4), 32'(m4_cout));
      chk("zero4", 32'(zero4), 32'(m4_zero));
      chk("ovf4",  32'(ovf4),  32'(m4_ovf));
    end
  end

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic eco, input logic ez,
                       input logic eov, input string tag);
    int cyc;
    @(negedge clk);
    a16 = a; b16 = b; c16 = c; s16 = 1'b1;
    @(negedge clk);
    s16 = 1'b0; a16 = ~a; b16 = b ^ 16'h5A5A; c16 = ~c;
    cyc = 1;
    while (!done16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("add16 %s A=%h B=%h cin=%0b -> Sum=%h cout=%0b zero=%0b ovf=%0b cycles=%0d",
             tag, a, b, c, sum16, cout16, zero16, ovf16, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
    chk({tag, "_sum"},  32'(sum16),  32'(es));
    chk({tag, "_cout"}, 32'(cout16), 32'(eco));
    chk({tag, "_zero"}, 32'(zero16), 32'(ez));
    chk({tag, "_ovf"},  32'(ovf16),  32'(eov));
    chk({tag, "_model"}, 32'({m16_cout, m16_zero, m16_ovf, m16_sum}),
        32'({eco, ez, eov, es}));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [3:0] es, input logic eco, input logic ez,
                      input logic eov, input string tag);
    int cyc;
    @(negedge clk);
    a4 = a; b4 = b; c4 = c; s4 = 1'b1;
    @(negedge clk);
    s4 = 1'b0; a4 = ~a; b4 = ~b; c4 = ~c;
    cyc = 1;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("add4 %s A=%h B=%h cin=%0b -> Sum=%h cout=%0b zero=%0b ovf=%0b cycles=%0d",
             tag, a, b, c, sum4, cout4, zero4, ovf4, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd2);
    chk({tag, "_sum"},  32'(sum4),  32'(es));
    chk({tag, "_cout"}, 32'(cout4), 32'(eco));
    chk({tag, "_zero"}, 32'(zero4), 32'(ez));
    chk({tag, "_ovf"},  32'(ovf4),  32'(eov));
    chk({tag, "_model"}, 32'({m4_cout, m4_zero, m4_ovf, m4_sum}),
        32'({eco, ez, eov, es}));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    rst = 1'b1;
    s16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    s4  = 1'b0; a4  = '0; b4  = '0; c4  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sum16", 32'(sum16), 32'd0);
    chk("reset_busy16", 32'(busy16), 32'd0);
    rst = 1'b0;

    run16(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, "t1");
    run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, "t2");
    run16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1, "t3a");
    run16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, "t3b");
    run16(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "t4a");
    run16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, "t4b");

    // start held high with operands changing: only the first request runs
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; c16 = 1'b0; s16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = 16'hF0F0 + 16'(i); b16 = 16'h0F0F;
    end
    s16 = 1'b0;
    cyc = 0;
    while (!done16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("add16 hold A=1111 B=2222 -> Sum=%h cout=%0b", sum16, cout16);
    chk("hold_sum", 32'(sum16), 32'h3333);
    chk("hold_cout", 32'(cout16), 32'd0);

    // async reset two edges into a run
    @(negedge clk);
    a16 = 16'h0011; b16 = 16'h0022; c16 = 1'b0; s16 = 1'b1;
    @(posedge clk);
    s16 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("reset mid-run -> busy=%0b done=%0b Sum=%h cout=%0b zero=%0b ovf=%0b",
             busy16, done16, sum16, cout16, zero16, ovf16);
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_done", 32'(done16), 32'd0);
    chk("rst_sum",  32'(sum16),  32'd0);
    chk("rst_cout", 32'(cout16), 32'd0);
    chk("rst_zero", 32'(zero16), 32'd0);
    chk("rst_ovf",  32'(ovf16),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run16(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "post_rst");

    run4(4'h8, 4'h8, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, "w4a");
    run4(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, "w4b");
    run4(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, "w4c");

    // back-to-back: start held high, spacing between done pulses
    @(negedge clk);
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; s4 = 1'b1;
    a16 = 16'h0100; b16 = 16'h0200; c16 = 1'b0; s16 = 1'b1;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done4 && cyc < 20);
    $display("b2b w4 Sum=%h done spacing=%0d", sum4, cyc);
    chk("b2b4_spacing", 32'(cyc), 32'd3);
    chk("b2b4_sum", 32'(sum4), 32'h7);
    cyc = 0;
    while (!done16 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done16 && cyc < 20);
    $display("b2b w16 Sum=%h done spacing=%0d", sum16, cyc);
    chk("b2b16_spacing", 32'(cyc), 32'd6);
    chk("b2b16_sum", 32'(sum16), 32'h0300);
    s4 = 1'b0; s16 = 1'b0;
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
